// File: rtl/ltc2624_spi_sequencer.sv
// Multi-channel SPI master for the quad 12-bit LTC2624 DAC.
// One START streams a 32-bit frame to every channel selected in the mask.
module ltc2624_spi_sequencer #(
  parameter int CLK_DIV = 2,
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 12,
  parameter int CS_GAP  = 4,
  parameter int CLR_CYC = 8
) (
  input  logic                       CLOCK,
  input  logic                       RESET,
  input  logic                       START,
  input  logic [3:0]                 CMD,
  input  logic [NUM_CH-1:0]          CHAN_MASK,
  input  logic [NUM_CH*DATA_W-1:0]   DATA,
  input  logic                       CLR_REQ,
  input  logic                       SPI_MISO,
  output logic                       SPI_SCK,
  output logic                       SPI_MOSI,
  output logic                       DAC_CS,
  output logic                       DAC_CLR,
  output logic                       BUSY,
  output logic                       DONE,
  output logic [31:0]                ECHO,
  output logic                       ECHO_VALID
);

  localparam int DW   = $clog2(CLK_DIV) + 1;
  localparam int AMAX = (CS_GAP > CLR_CYC) ? CS_GAP : CLR_CYC;
  localparam int AW   = $clog2(AMAX) + 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SCK_LO,
    SCK_HI,
    CS_HOLD,
    GAP,
    CLEAR
  } state_t;

  state_t                    state_q, state_d;
  logic [DW-1:0]             div_q, div_d;
  logic [AW-1:0]             aux_q, aux_d;
  logic [4:0]                bit_q, bit_d;
  logic [31:0]               tx_q, tx_d;
  logic [31:0]               rx_q, rx_d;
  logic [3:0]                cmd_q, cmd_d;
  logic [NUM_CH-1:0]         pend_q, pend_d;
  logic [NUM_CH*DATA_W-1:0]  data_q, data_d;
  logic [1:0]                cur_q, cur_d;
  logic                      sck_q, sck_d;
  logic                      mosi_q, mosi_d;
  logic                      cs_q, cs_d;
  logic                      clr_q, clr_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic [31:0]               echo_q, echo_d;
  logic                      ev_q, ev_d;

  logic [1:0]                sel;
  logic [DATA_W-1:0]         samp;
  logic [31:0]               frame;
  logic                      div_end;

  // lowest-index pending channel wins
  always_comb begin
    sel = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pend_q[i]) sel = 2'(i);
    end
  end

  always_comb begin
    samp          = data_q[sel*DATA_W +: DATA_W];
    frame         = '0;
    frame[23:20]  = cmd_q;
    frame[19:16]  = {2'b00, sel};
    frame[15 -: DATA_W] = samp;
  end

  assign div_end = (div_q == DW'(CLK_DIV - 1));

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    aux_d   = aux_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    cmd_d   = cmd_q;
    pend_d  = pend_q;
    data_d  = data_q;
    cur_d   = cur_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    cs_d    = cs_q;
    clr_d   = clr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    echo_d  = echo_q;
    ev_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        clr_d  = 1'b1;
        sck_d  = 1'b0;
        cs_d   = 1'b1;
        busy_d = 1'b0;
        if (START) begin
          if (|CHAN_MASK) begin
            cmd_d   = CMD;
            pend_d  = CHAN_MASK;
            data_d  = DATA;
            busy_d  = 1'b1;
            state_d = LOAD;
          end else begin
            done_d  = 1'b1;
          end
        end else if (CLR_REQ) begin
          clr_d   = 1'b0;
          busy_d  = 1'b1;
          aux_d   = '0;
          state_d = CLEAR;
        end
      end
      LOAD: begin
        tx_d    = frame;
        mosi_d  = frame[31];
        cs_d    = 1'b0;
        sck_d   = 1'b0;
        bit_d   = 5'd31;
        div_d   = '0;
        cur_d   = sel;
        state_d = SCK_LO;
      end
      SCK_LO: begin
        if (div_end) begin
          div_d   = '0;
          sck_d   = 1'b1;
          rx_d    = {rx_q[30:0], SPI_MISO};
          state_d = SCK_HI;
        end else begin
          div_d   = div_q + DW'(1);
        end
      end
      SCK_HI: begin
        if (div_end) begin
          div_d = '0;
          sck_d = 1'b0;
          if (bit_q == 5'd0) begin
            state_d = CS_HOLD;
          end else begin
            bit_d   = bit_q - 5'd1;
            tx_d    = {tx_q[30:0], 1'b0};
            mosi_d  = tx_q[30];
            state_d = SCK_LO;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      CS_HOLD: begin
        if (div_end) begin
          div_d   = '0;
          cs_d    = 1'b1;
          echo_d  = rx_q;
          ev_d    = 1'b1;
          aux_d   = '0;
          state_d = GAP;
        end else begin
          div_d   = div_q + DW'(1);
        end
      end
      GAP: begin
        if (aux_q == AW'(CS_GAP - 1)) begin
          pend_d = pend_q & ~(NUM_CH'(1) << cur_q);
          if (pend_d == '0) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = LOAD;
          end
        end else begin
          aux_d = aux_q + AW'(1);
        end
      end
      CLEAR: begin
        if (aux_q == AW'(CLR_CYC - 1)) begin
          clr_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          aux_d = aux_q + AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= IDLE;
      div_q   <= '0;
      aux_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      cmd_q   <= '0;
      pend_q  <= '0;
      data_q  <= '0;
      cur_q   <= '0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      cs_q    <= 1'b1;
      clr_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      echo_q  <= '0;
      ev_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      aux_q   <= aux_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      cmd_q   <= cmd_d;
      pend_q  <= pend_d;
      data_q  <= data_d;
      cur_q   <= cur_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      cs_q    <= cs_d;
      clr_q   <= clr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      echo_q  <= echo_d;
      ev_q    <= ev_d;
    end
  end

  assign SPI_SCK    = sck_q;
  assign SPI_MOSI   = mosi_q;
  assign DAC_CS     = cs_q;
  assign DAC_CLR    = clr_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign ECHO       = echo_q;
  assign ECHO_VALID = ev_q;

endmodule
